// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for dmem_arbiter: request/grant handshake plus registered read return.
interface dmem_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-requester sequencer in front of a single-port data memory.
// Optional address range check enabled by defining DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_arbiter_if.slave         m0,
  dmem_arbiter_if.slave         m1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t                state, state_nx;
  logic                  last;
  logic                  owner;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic                  load;
  logic                  win;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic                  serve;
  logic                  addr_ok;
  logic [1:0]            rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q [2];

  assign serve = (state == SERVE);

`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH-3:0] DEPTH_IDX = (ADDR_WIDTH-2)'(MEM_DEPTH);
  logic [1:0] err_q;

  assign addr_ok = (lat_addr[ADDR_WIDTH-1:2] < DEPTH_IDX);
  assign m0.err  = err_q[0];
  assign m1.err  = err_q[1];
`else
  assign addr_ok = 1'b1;
  assign m0.err  = 1'b0;
  assign m1.err  = 1'b0;
`endif

  // In SERVE the owner's req is still high, so only the other side can win the next slot.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    win      = owner;
    case (state)
      IDLE: begin
        if (m0.req || m1.req) begin
          load     = 1'b1;
          state_nx = SERVE;
          if (m0.req && m1.req) win = ~last;
          else                  win = m1.req;
        end
      end
      SERVE: begin
        if (owner ? m0.req : m1.req) begin
          load = 1'b1;
          win  = ~owner;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign sel_we    = win ? m1.we    : m0.we;
  assign sel_addr  = win ? m1.addr  : m0.addr;
  assign sel_wdata = win ? m1.wdata : m0.wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nx;
      if (serve) last <= owner;
      if (load) begin
        owner     <= win;
        lat_we    <= sel_we;
        lat_addr  <= sel_addr;
        lat_wdata <= sel_wdata;
      end
    end
  end

  // Memory bus follows the latch, so address/data hold their last values while idle.
  assign mem_we = serve && lat_we && addr_ok;
  assign mem_a  = lat_addr;
  assign mem_di = lat_wdata;

  assign m0.gnt = serve && !owner;
  assign m1.gnt = serve &&  owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q   <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      rvalid_q <= '0;
      if (serve && !lat_we) begin
        rvalid_q[owner] <= 1'b1;
        rdata_q[owner]  <= addr_ok ? mem_rd : '0;
      end
    end
  end

`ifdef DMEM_ARB_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= '0;
      if (serve && !addr_ok) err_q[owner] <= 1'b1;
    end
  end
`endif

  assign m0.rvalid = rvalid_q[0];
  assign m1.rvalid = rvalid_q[1];
  assign m0.rdata  = rdata_q[0];
  assign m1.rdata  = rdata_q[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter with a small behavioural memory attached.
module tb_dmem_arbiter;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  typedef struct {
    logic          rv;
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_di;
  logic [DW-1:0] mem_rd;
  logic [DW-1:0] mem   [8] = '{default: '0};
  logic [DW-1:0] model [8] = '{default: '0};

  int   total = 0;
  int   bad   = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m0_bus ();
  dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_bus ();

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .m0     (m0_bus),
    .m1     (m1_bus),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_di (mem_di),
    .mem_rd (mem_rd)
  );

  always @(posedge clk) if (mem_we) mem[mem_a[4:2]] <= mem_di;
  assign mem_rd = mem[mem_a[4:2]];

  task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [AW-1:0] addr);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    return addr[AW-1:2] < DEPTH;
`else
    return 1'b1;
`endif
  endfunction

  task automatic drive(input bit who, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (who) begin
      m1_bus.req = req; m1_bus.we = we; m1_bus.addr = addr; m1_bus.wdata = wdata;
    end else begin
      m0_bus.req = req; m0_bus.we = we; m0_bus.addr = addr; m0_bus.wdata = wdata;
    end
  endtask

  task automatic drop_req(input bit who);
    if (who) m1_bus.req = 1'b0;
    else     m0_bus.req = 1'b0;
  endtask

  // Called when the bench sees a grant: update the reference memory or queue the return.
  task automatic note_grant(input bit who, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata);
    exp_t e;
    bit   ok;
    ok = in_range(addr);
    e.rv   = !we;
    e.err  = !ok;
    e.data = ok ? model[addr[4:2]] : '0;
    if (we && ok) model[addr[4:2]] = wdata;
    if (!we || !ok) begin
      if (who) q1.push_back(e);
      else     q0.push_back(e);
    end
  endtask

  task automatic apply_stimulus(input bit who, input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata);
    drive(who, 1'b1, we, addr, wdata);
    @(negedge clk);
    check_output(who ? "m1_gnt" : "m0_gnt", who ? m1_bus.gnt : m0_bus.gnt, 1);
    check_output("other_gnt", who ? m0_bus.gnt : m1_bus.gnt, 0);
    check_output("mem_a", mem_a, addr);
    check_output("mem_we", mem_we, we && in_range(addr));
    note_grant(who, we, addr, wdata);
    drop_req(who);
    @(negedge clk);
  endtask

  task automatic check_return(input bit who);
    exp_t e;
    logic rv, er;
    logic [DW-1:0] rd;
    rv = who ? m1_bus.rvalid : m0_bus.rvalid;
    er = who ? m1_bus.err    : m0_bus.err;
    rd = who ? m1_bus.rdata  : m0_bus.rdata;
    if (rv || er) begin
      if ((who ? q1.size() : q0.size()) == 0) begin
        check_output(who ? "m1_unexpected_ret" : "m0_unexpected_ret", {rv, er}, 0);
      end else begin
        e = who ? q1.pop_front() : q0.pop_front();
        check_output(who ? "m1_rvalid" : "m0_rvalid", rv, e.rv);
        check_output(who ? "m1_err" : "m0_err", er, e.err);
        if (e.rv) check_output(who ? "m1_rdata" : "m0_rdata", rd, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_output("double_gnt", m0_bus.gnt & m1_bus.gnt, 0);
      check_return(1'b0);
      check_return(1'b1);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  initial begin
    logic [DW-1:0] sum;
    int m0_k;

    do_reset();
    check_output("rst_m0_gnt", m0_bus.gnt, 0);
    check_output("rst_m1_gnt", m1_bus.gnt, 0);
    check_output("rst_m0_rvalid", m0_bus.rvalid, 0);
    check_output("rst_m1_rdata", m1_bus.rdata, 0);
    check_output("rst_mem_we", mem_we, 0);
    check_output("rst_mem_a", mem_a, 0);
    check_output("rst_mem_di", mem_di, 0);
    check_output("rst_m0_err", m0_bus.err, 0);

    // Host write then read-back.
    apply_stimulus(1'b1, 1'b1, 32'h4, 32'h0000_0005);
    apply_stimulus(1'b1, 1'b0, 32'h4, '0);
    check_output("m1_readback", m1_bus.rdata, 32'h0000_0005);

    // Simultaneous reads after reset: m0 first, m1 back-to-back.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h0, '0);
    drive(1'b1, 1'b1, 1'b0, 32'h4, '0);
    @(negedge clk);
    check_output("tie_m0_gnt", m0_bus.gnt, 1);
    check_output("tie_m1_gnt", m1_bus.gnt, 0);
    note_grant(1'b0, 1'b0, 32'h0, '0);
    drop_req(1'b0);
    @(negedge clk);
    check_output("b2b_m1_gnt", m1_bus.gnt, 1);
    check_output("b2b_m0_gnt", m0_bus.gnt, 0);
    check_output("b2b_m0_rvalid", m0_bus.rvalid, 1);
    note_grant(1'b1, 1'b0, 32'h4, '0);
    drop_req(1'b1);
    @(negedge clk);
    check_output("b2b_m1_rvalid", m1_bus.rvalid, 1);
    check_output("b2b_m0_rvalid_gone", m0_bus.rvalid, 0);
    check_output("b2b_idle_gnt", m0_bus.gnt | m1_bus.gnt, 0);

    // Both hold req for 8 accesses: m0 writes 0xC, m1 reads it back each turn.
    do_reset();
    m0_k = 0;
    drive(1'b0, 1'b1, 1'b1, 32'hC, 32'h100);
    drive(1'b1, 1'b1, 1'b0, 32'hC, '0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_output("alt_m0_gnt", m0_bus.gnt, (i % 2) == 0);
      check_output("alt_m1_gnt", m1_bus.gnt, (i % 2) == 1);
      if ((i % 2) == 0) begin
        note_grant(1'b0, 1'b1, 32'hC, 32'h100 + m0_k);
        m0_k++;
        m0_bus.wdata = 32'h100 + m0_k;
        if (i == 6) drop_req(1'b0);
      end else begin
        note_grant(1'b1, 1'b0, 32'hC, '0);
        if (i == 7) drop_req(1'b1);
      end
    end
    @(negedge clk);
    check_output("alt_idle_gnt", m0_bus.gnt | m1_bus.gnt, 0);
    check_output("alt_last_rdata", m1_bus.rdata, 32'h103);

    // Reset during the grant cycle of a write must cancel it.
    drive(1'b0, 1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF);
    @(negedge clk);
    check_output("rw_gnt", m0_bus.gnt, 1);
    check_output("rw_mem_we_before", mem_we, 1);
    rst = 1'b1;
    #1;
    check_output("rw_mem_we_reset", mem_we, 0);
    drop_req(1'b0);
    @(negedge clk);
    rst = 1'b0;
    q0.delete();
    q1.delete();
    apply_stimulus(1'b0, 1'b0, 32'h8, '0);
    check_output("rw_read_8", m0_bus.rdata, 32'h0);

    // Fibonacci step through requester 0.
    apply_stimulus(1'b0, 1'b1, 32'h0, 32'h1);
    apply_stimulus(1'b0, 1'b1, 32'h4, 32'h1);
    apply_stimulus(1'b0, 1'b0, 32'h0, '0);
    apply_stimulus(1'b0, 1'b0, 32'h4, '0);
    sum = model[0] + model[1];
    apply_stimulus(1'b0, 1'b1, 32'h8, sum);
    apply_stimulus(1'b0, 1'b0, 32'h8, '0);
    check_output("fib_result", m0_bus.rdata, 32'h0000_0002);

    // Low address bits pass straight through.
    apply_stimulus(1'b1, 1'b0, 32'h5, '0);
    check_output("unaligned_rdata", m1_bus.rdata, 32'h1);

`ifdef DMEM_ARB_RANGE_CHECK_EN
    apply_stimulus(1'b0, 1'b1, 32'h10, 32'hCAFE_F00D);
    check_output("oor_mem_untouched", mem[4], 32'h0);
    apply_stimulus(1'b0, 1'b0, 32'h10, '0);
    check_output("oor_read_rdata", m0_bus.rdata, 32'h0);
`endif

    @(negedge clk);
    check_output("pending_returns", q0.size() + q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
